// File: rtl/mem_pkg.sv
// Shared types and constants for the memory-access pipeline stage.
package mem_pkg;

    localparam int unsigned DATA_W      = 16;
    localparam int unsigned RD_W        = 4;
    localparam int unsigned CNT_W       = 2;
    localparam int unsigned HOLD_CYCLES = 3;

    localparam logic [1:0] MEM_ACC  = 2'b01;
    localparam logic [1:0] MEM_IDLE = 2'b00;

    localparam logic [DATA_W-1:0] SERIAL_DATA_ADDR = 16'hBF00;
    localparam logic [DATA_W-1:0] SERIAL_STAT_ADDR = 16'hBF01;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_HOLD    = 2'd1,
        ST_CAPTURE = 2'd2
    } state_e;

    // Writeback fields kept for an in-flight memory request
    typedef struct packed {
        logic            read;
        logic [RD_W-1:0] rd;
        logic            regwrite;
    } pend_t;

endpackage

// File: rtl/mem_access_stage_if.sv
// Upstream, memory-controller and writeback signals of the memory-access stage.
interface mem_access_stage_if;
    import mem_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              in_read;
    logic              in_write;
    logic [DATA_W-1:0] in_addr;
    logic [DATA_W-1:0] in_wdata;
    logic [DATA_W-1:0] in_alu;
    logic [RD_W-1:0]   in_rd;
    logic              in_regwrite;

    logic [DATA_W-1:0] address;
    logic [DATA_W-1:0] dataIn;
    logic [1:0]        memRead;
    logic [1:0]        memWrite;
    logic [DATA_W-1:0] dataOut;

    logic              wb_valid;
    logic [DATA_W-1:0] wb_data;
    logic [RD_W-1:0]   wb_rd;
    logic              wb_regwrite;
    logic              err;

    // Stage side
    modport slave (
        input  in_valid, in_read, in_write, in_addr, in_wdata, in_alu, in_rd, in_regwrite,
        input  dataOut,
        output in_ready, address, dataIn, memRead, memWrite,
        output wb_valid, wb_data, wb_rd, wb_regwrite, err
    );

    // Pipeline / controller side
    modport master (
        output in_valid, in_read, in_write, in_addr, in_wdata, in_alu, in_rd, in_regwrite,
        output dataOut,
        input  in_ready, address, dataIn, memRead, memWrite,
        input  wb_valid, wb_data, wb_rd, wb_regwrite, err
    );

endinterface

// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: forwards ALU results or holds a load/store
// request stable toward a slow memory controller and captures the response.
module mem_access_stage
    import mem_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES_P = HOLD_CYCLES
) (
    input  logic              clk_i,
    input  logic              rst_i,
    mem_access_stage_if.slave bus_io
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES_P - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    pend_t             pend_q, pend_d;

    logic              in_ready_q, in_ready_d;
    logic [1:0]        mem_read_q, mem_read_d;
    logic [1:0]        mem_write_q, mem_write_d;
    logic [DATA_W-1:0] address_q, address_d;
    logic [DATA_W-1:0] data_in_q, data_in_d;
    logic              wb_valid_q, wb_valid_d;
    logic [DATA_W-1:0] wb_data_q, wb_data_d;
    logic [RD_W-1:0]   wb_rd_q, wb_rd_d;
    logic              wb_regwrite_q, wb_regwrite_d;
    logic              err_q, err_d;

    logic accept_c;
    logic bad_req_c;
    logic mem_req_c;

    assign accept_c  = bus_io.in_valid && in_ready_q;
    assign bad_req_c = bus_io.in_read && bus_io.in_write;
    assign mem_req_c = accept_c && (bus_io.in_read ^ bus_io.in_write);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend_d  = pend_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req_c) begin
                    state_d         = ST_HOLD;
                    cnt_d           = '0;
                    pend_d.read     = bus_io.in_read;
                    pend_d.rd       = bus_io.in_rd;
                    pend_d.regwrite = bus_io.in_regwrite;
                end
            end
            ST_HOLD: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_CAPTURE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CAPTURE: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    // Output logic, evaluated one cycle ahead so every output is a flop
    always_comb begin
        in_ready_d    = (state_d == ST_IDLE);
        mem_read_d    = MEM_IDLE;
        mem_write_d   = MEM_IDLE;
        address_d     = address_q;
        data_in_d     = data_in_q;
        wb_valid_d    = 1'b0;
        wb_data_d     = wb_data_q;
        wb_rd_d       = wb_rd_q;
        wb_regwrite_d = wb_regwrite_q;
        err_d         = 1'b0;

        if (mem_req_c) begin
            address_d = bus_io.in_addr;
            data_in_d = bus_io.in_wdata;
        end

        if (state_d == ST_HOLD) begin
            mem_read_d  = pend_d.read ? MEM_ACC : MEM_IDLE;
            mem_write_d = pend_d.read ? MEM_IDLE : MEM_ACC;
        end

        // Pass-through; a request with both read and write set lands here too
        if (accept_c && !mem_req_c) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = bus_io.in_alu;
            wb_rd_d       = bus_io.in_rd;
            wb_regwrite_d = bus_io.in_regwrite && !bad_req_c;
            err_d         = bad_req_c;
        end

        if (state_q == ST_CAPTURE) begin
            wb_valid_d    = 1'b1;
            wb_data_d     = pend_q.read ? bus_io.dataOut : '0;
            wb_rd_d       = pend_q.rd;
            wb_regwrite_d = pend_q.regwrite;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            in_ready_q    <= 1'b1;
            mem_read_q    <= MEM_IDLE;
            mem_write_q   <= MEM_IDLE;
            address_q     <= '0;
            data_in_q     <= '0;
            wb_valid_q    <= 1'b0;
            wb_data_q     <= '0;
            wb_rd_q       <= '0;
            wb_regwrite_q <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            in_ready_q    <= in_ready_d;
            mem_read_q    <= mem_read_d;
            mem_write_q   <= mem_write_d;
            address_q     <= address_d;
            data_in_q     <= data_in_d;
            wb_valid_q    <= wb_valid_d;
            wb_data_q     <= wb_data_d;
            wb_rd_q       <= wb_rd_d;
            wb_regwrite_q <= wb_regwrite_d;
            err_q         <= err_d;
        end
    end

    assign bus_io.in_ready    = in_ready_q;
    assign bus_io.memRead     = mem_read_q;
    assign bus_io.memWrite    = mem_write_q;
    assign bus_io.address     = address_q;
    assign bus_io.dataIn      = data_in_q;
    assign bus_io.wb_valid    = wb_valid_q;
    assign bus_io.wb_data     = wb_data_q;
    assign bus_io.wb_rd       = wb_rd_q;
    assign bus_io.wb_regwrite = wb_regwrite_q;
    assign bus_io.err         = err_q;

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 HOLD_CYCLES, 3, cycles each memory request is held stable toward the memory controller; values below 3 are unsupported.
REQ-002 CLK  in  1  single clock; all state updates on its rising edge.
REQ-003 RST  in  1  reset, synchronous, active-high.
REQ-004 in_valid  in  1  upstream (EX/MEM) presents an instruction.
REQ-005 in_ready  out  1  stage can accept; upstream stalls while low.
REQ-006 in_read / in_write  in  1 each  instruction is a load / a store.
REQ-007 in_addr  in  16  memory or serial-port address (0xBF00 data, 0xBF01 status).
REQ-008 in_wdata  in  16  store data.
REQ-009 in_alu  in  16  result forwarded unchanged for non-memory instructions.
REQ-010 in_rd / in_regwrite  in  4 / 1  writeback destination and enable.
REQ-011 address / dataIn  out  16 each  to the memory controller.
REQ-012 memRead / memWrite  out  2 each  to the memory controller; 2'b01 = access, 2'b00 = idle.
REQ-013 dataOut  in  16  read data from the memory controller.
REQ-014 wb_valid / wb_data / wb_rd / wb_regwrite  out  1 / 16 / 4 / 1  result to the writeback stage.
REQ-015 err  out  1  one-cycle pulse on an illegal request.

Function
REQ-016 FSM states: IDLE, HOLD, CAPTURE; in_ready SHALL be 1 only in IDLE.
REQ-017 Acceptance SHALL occur on a rising edge with in_valid && in_ready; all in_* values are registered at that edge.
REQ-018 Pass-through (in_read = in_write = 0): the FSM stays in IDLE; wb_valid = 1 in the next cycle, with wb_data = registered in_alu; back-to-back acceptance SHALL be supported.
REQ-019 Memory request (exactly one of in_read / in_write): IDLE -> HOLD, with the hold counter cleared to 0.
REQ-020 In HOLD: address = registered address, dataIn = registered wdata, and memRead or memWrite = 2'b01 for exactly HOLD_CYCLES cycles; HOLD -> CAPTURE when the counter reaches HOLD_CYCLES-1.
REQ-021 In CAPTURE: memRead = memWrite = 2'b00; for reads, dataOut SHALL be latched into wb_data at the end of the cycle; for writes, wb_data = 0; CAPTURE -> IDLE.
REQ-022 wb_valid SHALL be 1 in the cycle after CAPTURE, so a request accepted at the edge ending cycle T has wb_valid in cycle T+5; in_ready = 1 again in that same cycle.
REQ-023 wb_valid SHALL be a single-cycle pulse; it has no backpressure, and wb_rd / wb_regwrite carry the registered values.
REQ-024 Outside HOLD, memRead = memWrite = 2'b00, and address / dataIn hold their last values.
REQ-025 in_read && in_write both set: err pulses in the next cycle, no memory access occurs, and the instruction is treated as pass-through with wb_regwrite forced to 0.
REQ-026 Serial addresses 0xBF00 / 0xBF01 SHALL be handled identically to RAM addresses (decode belongs to the memory controller).
REQ-027 in_valid = 0 in IDLE: no state change, and wb_valid = 0 next cycle.

Reset
REQ-028 While RST = 1 at a rising edge: state = IDLE, counter = 0, memRead = memWrite = 2'b00, address = dataIn = 0, wb_valid = wb_regwrite = err = 0, wb_data = 0, wb_rd = 0, in_ready = 1 in the following cycle.
REQ-029 RST asserted during HOLD or CAPTURE SHALL abort the request: no wb_valid is produced for it, and controls are idle from the next cycle.

Structure
REQ-030 Shared package mem_pkg SHALL hold: MEM_ACC = 2'b01, MEM_IDLE = 2'b00, SERIAL_DATA_ADDR = 16'hBF00, SERIAL_STAT_ADDR = 16'hBF01, HOLD_CYCLES default, and the FSM state enum.
REQ-031 The block SHALL be a single module with no sub-module; the hold counter is 2 bits wide and inline.

Verification
REQ-032 Pass-through stream: three back-to-back instructions with in_alu = 0x0001 / 0x0002 / 0x0003 -> wb_valid high for 3 consecutive cycles with matching data, and in_ready constantly 1.
REQ-033 Load: addr 0x4000, controller model returns 0xBEEF -> memRead = 01 for exactly 3 cycles, wb_data = 0xBEEF at T+5, and in_ready low for 4 cycles.
REQ-034 Store: addr 0x4001, wdata 0x1234 -> memWrite = 01 and dataIn = 0x1234 for 3 cycles, memRead = 00 throughout, and wb_valid at T+5 with wb_regwrite = 0.
REQ-035 Both in_read and in_write set -> err pulse, memRead = memWrite = 00 throughout, and wb_regwrite = 0.
REQ-036 RST asserted in the 2nd HOLD cycle of a load -> controls return to 00 the next cycle, no wb_valid occurs, and in_ready = 1 after reset releases.
REQ-037 Load from 0xBF01 against a free-running two-phase controller model started at both phase offsets -> correct status word captured in both cases.
